adc_capture_scheduler: RTL and testbench
========================================

Name: adc_capture_scheduler

Overview:
- Shares the single 32-bit Xillybus capture FIFO between NUM_ADC synchronized ADC receive channels.
- Each adc_interface channel delivers one 32-bit word per conversion (all channels converge on the same adc_sync).
- The block buffers one word per channel, then emits each complete sample set to the FIFO in channel order, preceded by a header word.
- Honours FIFO backpressure and Xillybus open/close; sits between the per-ADC receivers and the capture FIFO, all in the capture_clk domain.

Parameters:
- NUM_ADC, 4, number of ADC channels; legal range 1..8.
- DATA_W, 32, word width; fixed to the FIFO width.

Ports:
- capture_clk  in  1  sole clock.
- capture_rst_n  in  1  asynchronous active-low reset.
- user_r_read_32_open  in  1  Xillybus read pipe open.
- adc_word  in  NUM_ADC*32  channel k word at bits [32k+31:32k].
- adc_valid  in  NUM_ADC  one-cycle strobe per channel; adc_word is valid that cycle.
- capture_full  in  1  FIFO full.
- capture_data  out  32  FIFO write data.
- capture_en  out  1  FIFO write enable.
- overrun_any  out  1  sticky OR of all overrun flags since open; cleared on close.

Behaviour:
- One clock (capture_clk); reset is asynchronous and active-low (capture_rst_n).
- Reset values: state IDLE, all slots empty, seq=0, overrun flags 0, capture_en=0, capture_data=0, overrun_any=0.
- Holding slot per channel: one 32-bit register plus a full flag.
  - adc_valid with slot empty: load word, set full.
  - adc_valid with slot full and not draining that channel this cycle: drop the new word, keep the old one, set sticky ovr[k].
  - adc_valid on the same cycle the slot drains: accept the new word; no overrun.
- capture_en is combinational: (state==HDR or state==DATA) && !capture_full && user_r_read_32_open. State and index advance only on cycles where capture_en=1.
- capture_data is muxed combinationally. In HDR: {8'hF5, seq[7:0], 8'h00, 8-bit ovr field, ovr[k] at bit k, unused bits 0}. In DATA: slot[idx].
- FSM:
  - IDLE: while !open, slots are cleared and adc_valid is ignored. When open=1, go to WAIT.
  - WAIT: when all slots are full, go to HDR. The header is presentable the cycle after the last slot fills (1-cycle latency).
  - HDR: on write, latch-clear the reported ovr bits (overruns arriving that same cycle are retained), seq<=seq+1 mod 256, idx<=0, go to DATA.
  - DATA: on write, empty slot[idx]. If idx==NUM_ADC-1 go to WAIT, else idx+1.
- Backpressure: while capture_full, hold state and data stable, capture_en=0. No word loss at the output; input loss only via overrun.
- Channels may refill while later channels are still draining; the next frame starts only once all slots are full again.
- Close mid-frame (open falls in any state): go to IDLE next edge, capture_en=0 combinationally that cycle, slots and seq cleared, ovr and overrun_any cleared. A partial frame is abandoned, not completed.
- Reset mid-operation: immediate return to reset values.
- seq wraps 255->0.

Optional Feature:
- ADC_FRAME_HEADER_EN defined: header word is emitted as above.
- Not defined: HDR state is skipped (WAIT goes directly to DATA), seq is not maintained, ovr is reported only via overrun_any, and the FIFO stream is raw channel words.

Decomposition:
- Package adc_capture_pkg holds: HDR_MARKER=8'hF5, FSM state encoding (IDLE, WAIT, HDR, DATA), DATA_W.
- Sub-module adc_holding_slot, one instance per channel: register, full flag, load/drain/overrun logic.

Test Plan:
- Open, NUM_ADC=4, channels strobed with 0x1A1B1C1D, 0x2A2B2C2D, 0x3A3B3C3D, 0x4A4B4C4D -> FIFO gets F5000000, then the four words in order, capture_en high 5 consecutive cycles.
- Second set after the first -> header F5010000; after 256 sets -> header seq wraps to F5000000.
- capture_full held high 10 cycles mid-DATA -> capture_en=0 and capture_data stable throughout; resumes with the next word; no duplication or loss.
- Ch2 strobed twice before frame completion -> second word dropped, frame carries the first ch2 word, header F5xx0004, overrun_any=1.
- open dropped after header and 2 data words -> capture_en=0 that cycle, no further writes; reopen -> next header seq=00.
- ADC_FRAME_HEADER_EN undefined -> only 4 data words per set, no F5 words in the stream.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture scheduler: word width, header
// marker byte and the frame-emission state encoding.
package adc_capture_pkg;

    localparam int DATA_W = 32;

    localparam logic [7:0] HDR_MARKER = 8'hF5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HDR  = 2'd2,
        S_DATA = 2'd3
    } state_t;

endpackage

// File: rtl/adc_holding_slot.sv
// One-word holding register for a single ADC channel. A word is loaded when
// the slot is empty or is being drained this very cycle; a strobe that finds
// the slot occupied drops the new word and raises a sticky overrun flag.
module adc_holding_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              ovr_clr,
    input  logic              valid,
    input  logic [DATA_W-1:0] word,
    input  logic              drain,
    output logic [DATA_W-1:0] data,
    output logic              full,
    output logic              ovr
);

    logic load;
    logic overrun;

    assign load    = valid && (!full || drain);
    assign overrun = valid && full && !drain;

    // Holding register and occupancy: clear wins, then load, then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            full <= 1'b0;
        end else if (clear) begin
            data <= '0;
            full <= 1'b0;
        end else if (load) begin
            data <= word;
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    // Sticky overrun flag; a fresh overrun beats a header-driven clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr <= 1'b0;
        end else if (clear) begin
            ovr <= 1'b0;
        end else if (overrun) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_capture_scheduler.sv
// Collects one word per ADC channel and writes each complete sample set to
// the shared capture FIFO in channel order. With ADC_FRAME_HEADER_EN defined
// every set is preceded by a header word {F5, seq, 00, overrun bits};
// otherwise the FIFO stream carries raw channel words only.
module adc_capture_scheduler #(
    parameter int NUM_ADC = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      capture_clk,
    input  logic                      capture_rst_n,
    input  logic                      user_r_read_32_open,
    input  logic [NUM_ADC*DATA_W-1:0] adc_word,
    input  logic [NUM_ADC-1:0]        adc_valid,
    input  logic                      capture_full,
    output logic [DATA_W-1:0]         capture_data,
    output logic                      capture_en,
    output logic                      overrun_any
);

    import adc_capture_pkg::*;

    localparam int IDX_W = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  slot_data [NUM_ADC];
    logic [NUM_ADC-1:0] slot_full;
    logic [NUM_ADC-1:0] slot_ovr;
    logic [NUM_ADC-1:0] drain;
    logic               all_full;
    logic               ovr_clr;
    logic               overrun_q;
    logic               clear;

    assign clear    = !user_r_read_32_open;
    assign all_full = &slot_full;

`ifdef ADC_FRAME_HEADER_EN
    logic [7:0] seq;
    logic [7:0] ovr_field;

    assign ovr_clr = (state == S_HDR) && capture_en;

    // Spread the per-channel overrun flags into the 8-bit header field.
    always_comb begin
        ovr_field = '0;
        for (int k = 0; k < NUM_ADC; k++) begin
            ovr_field[k] = slot_ovr[k];
        end
    end

    // Frame sequence number: bumps on each header write, restarts on close.
    always_ff @(posedge capture_clk or negedge capture_rst_n) begin
        if (!capture_rst_n) begin
            seq <= 8'd0;
        end else if (clear) begin
            seq <= 8'd0;
        end else if (ovr_clr) begin
            seq <= seq + 8'd1;
        end
    end
`else
    assign ovr_clr = 1'b0;
`endif

    for (genvar k = 0; k < NUM_ADC; k++) begin : g_slot
        adc_holding_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (capture_clk),
            .rst_n   (capture_rst_n),
            .clear   (clear),
            .ovr_clr (ovr_clr),
            .valid   (adc_valid[k]),
            .word    (adc_word[k*DATA_W +: DATA_W]),
            .drain   (drain[k]),
            .data    (slot_data[k]),
            .full    (slot_full[k]),
            .ovr     (slot_ovr[k])
        );
    end

    // Only the slot currently being written to the FIFO is emptied.
    always_comb begin
        drain = '0;
        for (int k = 0; k < NUM_ADC; k++) begin
            drain[k] = (state == S_DATA) && capture_en && (idx == IDX_W'(k));
        end
    end

    // State register.
    always_ff @(posedge capture_clk or negedge capture_rst_n) begin
        if (!capture_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a closed pipe sends every state back to idle.
    always_comb begin
        next_state = state;
        if (!user_r_read_32_open) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: next_state = S_WAIT;
                S_WAIT: begin
                    if (all_full) begin
`ifdef ADC_FRAME_HEADER_EN
                        next_state = S_HDR;
`else
                        next_state = S_DATA;
`endif
                    end
                end
                S_HDR: begin
                    if (capture_en) next_state = S_DATA;
                end
                S_DATA: begin
                    if (capture_en && (idx == IDX_W'(NUM_ADC - 1))) next_state = S_WAIT;
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    // FIFO write strobe and data mux, held stable while the FIFO is full.
    always_comb begin
        capture_en   = ((state == S_HDR) || (state == S_DATA)) &&
                       !capture_full && user_r_read_32_open;
        capture_data = '0;
        if (state == S_DATA) begin
            for (int k = 0; k < NUM_ADC; k++) begin
                if (idx == IDX_W'(k)) capture_data = slot_data[k];
            end
        end
`ifdef ADC_FRAME_HEADER_EN
        else if (state == S_HDR) begin
            capture_data = {HDR_MARKER, seq, 8'h00, ovr_field};
        end
`endif
    end

    // Channel index within a frame: parked at 0 outside the data phase.
    always_ff @(posedge capture_clk or negedge capture_rst_n) begin
        if (!capture_rst_n) begin
            idx <= '0;
        end else if (state != S_DATA) begin
            idx <= '0;
        end else if (capture_en) begin
            idx <= idx + 1'b1;
        end
    end

    // Remembers any overrun since open, even after a header clears the flags.
    always_ff @(posedge capture_clk or negedge capture_rst_n) begin
        if (!capture_rst_n) begin
            overrun_q <= 1'b0;
        end else if (clear) begin
            overrun_q <= 1'b0;
        end else if (|slot_ovr) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun_any = overrun_q | (|slot_ovr);

endmodule

// File: tb/tb_adc_capture_scheduler.sv
// Directed testbench for adc_capture_scheduler (NUM_ADC=4). Expected FIFO
// streams are built from the stimulus; headers are expected only when
// ADC_FRAME_HEADER_EN is defined.
module tb_adc_capture_scheduler;

    localparam int NUM_ADC = 4;
`ifdef ADC_FRAME_HEADER_EN
    localparam int HDR_LEN = 1;
`else
    localparam int HDR_LEN = 0;
`endif
    localparam int FRAME_LEN = HDR_LEN + NUM_ADC;

    typedef struct {
        logic [3:0]   first_mask;
        logic [127:0] words;
    } vec_t;

    logic         capture_clk = 1'b0;
    logic         capture_rst_n;
    logic         user_r_read_32_open;
    logic [127:0] adc_word;
    logic [3:0]   adc_valid;
    logic         capture_full;
    logic [31:0]  capture_data;
    logic         capture_en;
    logic         overrun_any;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] mon_q[$];
    int          mon_cyc[$];
    logic        exp_ovr_any = 1'b0;
`ifdef ADC_FRAME_HEADER_EN
    logic [7:0]  exp_seq = 8'd0;
`endif

    vec_t         vecs[4];
    logic [127:0] w_a;
    logic [127:0] w_b;

    adc_capture_scheduler #(
        .NUM_ADC (NUM_ADC),
        .DATA_W  (32)
    ) dut (
        .capture_clk         (capture_clk),
        .capture_rst_n       (capture_rst_n),
        .user_r_read_32_open (user_r_read_32_open),
        .adc_word            (adc_word),
        .adc_valid           (adc_valid),
        .capture_full        (capture_full),
        .capture_data        (capture_data),
        .capture_en          (capture_en),
        .overrun_any         (overrun_any)
    );

    // Free-running clock.
    always #5 capture_clk = ~capture_clk;

    // Cycle counter used to prove a frame goes out as one burst.
    always @(posedge capture_clk) cyc <= cyc + 1;

    // FIFO model: record every accepted word at the falling edge.
    always @(negedge capture_clk) begin
        if (capture_en) begin
            mon_q.push_back(capture_data);
            mon_cyc.push_back(cyc);
        end
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input logic [127:0] words);
        @(posedge capture_clk);
        #1;
        adc_word  = words;
        adc_valid = mask;
        @(posedge capture_clk);
        #1;
        adc_valid = 4'b0000;
    endtask

    task automatic waitWords(input int n);
        for (int i = 0; i < 80; i++) begin
            if (mon_q.size() >= n) break;
            @(posedge capture_clk);
            #1;
        end
    endtask

    task automatic checkFrame(input string name, input logic [127:0] words,
                              input logic [3:0] ovr);
        waitWords(FRAME_LEN);
        checkOutput({name, " length"}, 32'(mon_q.size()), 32'(FRAME_LEN));
        exp_ovr_any = exp_ovr_any | (ovr != 4'b0000);
`ifdef ADC_FRAME_HEADER_EN
        if (mon_q.size() > 0) begin
            checkOutput({name, " header"}, mon_q[0], {8'hF5, exp_seq, 8'h00, 4'h0, ovr});
        end
        exp_seq = exp_seq + 8'd1;
`endif
        for (int k = 0; k < NUM_ADC; k++) begin
            if (mon_q.size() > HDR_LEN + k) begin
                checkOutput($sformatf("%s word%0d", name, k), mon_q[HDR_LEN + k],
                            words[32*k +: 32]);
            end
        end
        checkOutput({name, " overrun_any"}, {31'd0, overrun_any}, {31'd0, exp_ovr_any});
    endtask

    initial begin
        vecs[0] = '{first_mask: 4'b1111,
                    words: {32'h4A4B4C4D, 32'h3A3B3C3D, 32'h2A2B2C2D, 32'h1A1B1C1D}};
        vecs[1] = '{first_mask: 4'b0101,
                    words: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}};
        vecs[2] = '{first_mask: 4'b1000,
                    words: {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h00000000}};
        vecs[3] = '{first_mask: 4'b0001,
                    words: {32'hCAFEF00D, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF}};

        capture_rst_n       = 1'b0;
        user_r_read_32_open = 1'b0;
        adc_word            = '0;
        adc_valid           = '0;
        capture_full        = 1'b0;

        repeat (3) @(posedge capture_clk);
        #1;
        checkOutput("reset capture_en", {31'd0, capture_en}, 32'd0);
        checkOutput("reset capture_data", capture_data, 32'd0);
        checkOutput("reset overrun_any", {31'd0, overrun_any}, 32'd0);

        capture_rst_n       = 1'b1;
        user_r_read_32_open = 1'b1;
        @(posedge capture_clk);
        #1;
        checkOutput("open empty capture_en", {31'd0, capture_en}, 32'd0);

        // Table of sample sets with staggered channel arrival.
        for (int i = 0; i < 4; i++) begin
            mon_q.delete();
            mon_cyc.delete();
            applyStimulus(vecs[i].first_mask, vecs[i].words);
            applyStimulus(~vecs[i].first_mask, vecs[i].words);
            checkFrame($sformatf("vec%0d", i), vecs[i].words, 4'b0000);
            if (i == 0 && mon_cyc.size() == FRAME_LEN) begin
                checkOutput("vec0 burst span", 32'(mon_cyc[FRAME_LEN-1] - mon_cyc[0]),
                            32'(FRAME_LEN - 1));
            end
        end

        // Backpressure for 10 cycles after the first data word.
        w_a = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
        mon_q.delete();
        applyStimulus(4'b1111, w_a);
        waitWords(HDR_LEN + 1);
        capture_full = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge capture_clk);
            checkOutput($sformatf("bp%0d capture_en", j), {31'd0, capture_en}, 32'd0);
            checkOutput($sformatf("bp%0d capture_data", j), capture_data, w_a[63:32]);
        end
        checkOutput("bp no writes", 32'(mon_q.size()), 32'(HDR_LEN + 1));
        @(posedge capture_clk);
        #1;
        capture_full = 1'b0;
        checkFrame("bp frame", w_a, 4'b0000);

        // Channel 2 strobed twice before the set completes.
        w_a = {32'h40404040, 32'h30303030, 32'h20202020, 32'h10101010};
        w_b = {32'h40404040, 32'h3EEEEEEE, 32'h20202020, 32'h10101010};
        mon_q.delete();
        applyStimulus(4'b0100, w_a);
        applyStimulus(4'b0100, w_b);
        applyStimulus(4'b1011, w_a);
        checkFrame("ovr frame", w_a, 4'b0100);
        mon_q.delete();
        applyStimulus(4'b1111, vecs[1].words);
        checkFrame("post ovr frame", vecs[1].words, 4'b0000);

        // Close after header and two data words, then reopen.
        mon_q.delete();
        applyStimulus(4'b1111, vecs[2].words);
        waitWords(HDR_LEN + 2);
        user_r_read_32_open = 1'b0;
        #1;
        checkOutput("close capture_en", {31'd0, capture_en}, 32'd0);
        repeat (5) @(posedge capture_clk);
        #1;
        checkOutput("close no writes", 32'(mon_q.size()), 32'(HDR_LEN + 2));
        exp_ovr_any = 1'b0;
        checkOutput("close overrun_any", {31'd0, overrun_any}, 32'd0);
        user_r_read_32_open = 1'b1;
`ifdef ADC_FRAME_HEADER_EN
        exp_seq = 8'd0;
`endif
        mon_q.delete();
        applyStimulus(4'b1111, vecs[3].words);
        checkFrame("reopen frame", vecs[3].words, 4'b0000);

        // Run past 256 sets so the sequence number wraps.
        for (int i = 0; i < 256; i++) begin
            w_a = {32'hD0000000 + 32'(i), 32'hC0000000 + 32'(i),
                   32'hB0000000 + 32'(i), 32'hA0000000 + 32'(i)};
            mon_q.delete();
            applyStimulus(4'b1111, w_a);
            checkFrame($sformatf("wrap%0d", i), w_a, 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
